// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared constants for the instruction cache: AXI encodings, FSM states and default line geometry.
package ysyx_23060025_icache_pkg;

  localparam int ADDR_WIDTH_D   = 32;
  localparam int DATA_WIDTH_D   = 32;
  localparam int INDEX_WIDTH_D  = 4;
  localparam int OFFSET_WIDTH_D = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MISS_AR = 3'd2,
    ST_REFILL  = 3'd3,
    ST_RESP    = 3'd4
  } icache_state_t;

endpackage

// File: rtl/ysyx_23060025_icache_data.sv
// Instruction cache data array: one word written per refill beat, combinational word read.
module ysyx_23060025_icache_data
  import ysyx_23060025_icache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache; misses refill a full line with one AXI4 INCR burst,
// fence.i drops every valid bit in a single cycle.
//
// state    | meaning
// IDLE     | waiting for a fetch; applies pending/new fence.i invalidation first
// LOOKUP   | tag compare; a hit answers this cycle, a miss goes to MISS_AR
// MISS_AR  | line-aligned read address presented until arready
// REFILL   | accepting beats into the data array until rlast
// RESP     | refilled word returned with the sticky error flag
module ysyx_23060025_icache
  import ysyx_23060025_icache_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int INDEX_WIDTH  = INDEX_WIDTH_D,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_psel,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  output logic                  in_perr,
  input  logic                  fence_i_i,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  output logic                  hit_o,
  output logic                  miss_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_BITS = OFFSET_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << WORD_BITS;

  icache_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:2]  addr_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_q [LINES];
  logic [WORD_BITS-1:0]   cnt_q;
  logic                   err_q;
  logic                   fence_pend_q;
  logic                   resp_d_q;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag_a;
  logic [WORD_BITS-1:0]   word;
  logic                   hit;
  logic                   beat;
  logic                   last_beat;
  logic                   beat_err;
  logic                   fence_now;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   unused_paddr_lsb;

  assign unused_paddr_lsb = ^in_paddr[1:0];

  assign idx   = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag_a = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign word  = addr_q[OFFSET_WIDTH-1:2];

  assign hit       = valid_q[idx] && (tag_q[idx] == tag_a);
  assign beat      = (state == ST_REFILL) && axi_rvalid;
  assign last_beat = beat && axi_rlast;
  assign beat_err  = (axi_rresp != AXI_RESP_OKAY);
  // An invalidate in IDLE takes priority over a new request, which is then taken next cycle.
  assign fence_now = (state == ST_IDLE) && (fence_pend_q || fence_i_i);
  // The cycle right after a response still sees the old psel from the IFU, so it is ignored.
  assign accept    = (state == ST_IDLE) && !fence_now && in_psel && !resp_d_q;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_LOOKUP;
      ST_LOOKUP:  state_nxt = hit ? ST_IDLE : ST_MISS_AR;
      ST_MISS_AR: if (axi_arready) state_nxt = ST_REFILL;
      ST_REFILL:  if (last_beat) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_pready   = 1'b0;
    in_perr     = 1'b0;
    hit_o       = 1'b0;
    miss_o      = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    case (state)
      ST_LOOKUP: begin
        in_pready = hit;
        hit_o     = hit;
        miss_o    = !hit;
      end
      ST_MISS_AR: axi_arvalid = 1'b1;
      ST_REFILL:  axi_rready  = 1'b1;
      ST_RESP: begin
        in_pready = 1'b1;
        in_perr   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      resp_d_q     <= 1'b0;
    end else begin
      resp_d_q <= in_pready;
      if (accept) addr_q <= in_paddr[ADDR_WIDTH-1:2];

      if (fence_now)      fence_pend_q <= 1'b0;
      else if (fence_i_i) fence_pend_q <= 1'b1;

      if (beat) begin
        cnt_q <= axi_rlast ? '0 : cnt_q + 1'b1;
        err_q <= err_q | beat_err;
      end else if (state == ST_RESP) begin
        err_q <= 1'b0;
      end

      // A burst that ends early leaves the line invalid even without an error response.
      if (fence_now) valid_q <= '0;
      else if (last_beat)
        valid_q[idx] <= !(err_q || beat_err) && (cnt_q == WORD_BITS'(WORDS - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (last_beat) tag_q[idx] <= tag_a;
  end

  ysyx_23060025_icache_data #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (INDEX_WIDTH + WORD_BITS)
  ) u_data (
    .clock (clock),
    .we    (beat),
    .waddr ({idx, cnt_q}),
    .wdata (axi_rdata),
    .raddr ({idx, word}),
    .rdata (rd_word)
  );

  assign in_prdata   = in_pready ? rd_word : '0;
  assign axi_araddr  = {tag_a, idx, {OFFSET_WIDTH{1'b0}}};
  assign axi_arlen   = 8'(WORDS - 1);
  assign axi_arsize  = AXI_SIZE_4B;
  assign axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Scoreboarded bench for the instruction cache: random fetches against a line-level cache model
// and a behavioural AXI memory with stalls, beat gaps, error and short-burst injection.
module tb_ysyx_23060025_icache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_psel = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_perr;
  logic        fence_i_i = 1'b0;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = '0;
  logic        axi_rlast = 1'b0;
  logic        hit_o;
  logic        miss_o;

  ysyx_23060025_icache dut (
    .clock       (clock),
    .reset       (reset),
    .in_psel     (in_psel),
    .in_paddr    (in_paddr),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_perr     (in_perr),
    .fence_i_i   (fence_i_i),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .hit_o       (hit_o),
    .miss_o      (miss_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        hit;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ar_q[$];
  int unsigned ovr[int unsigned];

  // reference cache state: which line each index holds
  logic [15:0] m_valid = '0;
  logic [23:0] m_tag [16];

  int cur_stall = 0;
  int cur_err   = -1;
  int cur_len   = 4;
  int cur_gap   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
  endfunction

  // AXI memory: decisions at the falling edge take effect at the following rising edge
  int          stall_left = 0;
  bit          ar_seen = 0;
  bit          ar_stalled = 0;
  bit          burst = 0;
  int          beat_i = 0;
  logic [31:0] beat_line = '0;
  logic [31:0] prev_araddr = '0;

  always @(negedge clock) begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    axi_rresp   = 2'b00;
    if (!reset) begin
      ar_seen = 0; ar_stalled = 0; burst = 0;
    end else begin
      if (axi_arvalid) begin
        if (ar_stalled) check("ar_addr_stable", axi_araddr, prev_araddr);
        if (!ar_seen) begin
          ar_seen = 1;
          stall_left = cur_stall;
          check("ar_expected", 32'(ar_q.size() > 0), 1);
          if (ar_q.size() > 0) check("ar_addr", axi_araddr, ar_q[0]);
          check("ar_len", 32'(axi_arlen), 3);
          check("ar_size", 32'(axi_arsize), 2);
          check("ar_burst", 32'(axi_arburst), 1);
        end
        if (stall_left > 0) begin
          stall_left--;
          ar_stalled = 1;
          prev_araddr = axi_araddr;
        end else begin
          axi_arready = 1'b1;
          ar_seen = 0; ar_stalled = 0;
          burst = 1; beat_i = 0; beat_line = axi_araddr;
          if (ar_q.size() > 0) void'(ar_q.pop_front());
        end
      end
      if (burst && axi_rready && ($urandom_range(0, 99) >= cur_gap)) begin
        axi_rvalid = 1'b1;
        axi_rdata  = mem_word(beat_line + 32'(4 * beat_i));
        axi_rresp  = (beat_i == cur_err) ? 2'b10 : 2'b00;
        axi_rlast  = (beat_i == cur_len - 1);
        beat_i++;
        if (axi_rlast) burst = 0;
      end
    end
  end

  // response monitor
  int miss_seen = 0;
  always @(negedge clock) begin
    if (!reset) miss_seen = 0;
    else begin
      if (miss_o) miss_seen++;
      if (hit_o) check("hit_with_pready", 32'(in_pready), 1);
      if (in_pready) begin
        check("pready_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("prdata@%08h", e.addr), in_prdata, e.data);
          check($sformatf("perr@%08h", e.addr), 32'(in_perr), 32'(e.err));
          check($sformatf("hit_o@%08h", e.addr), 32'(hit_o), 32'(e.hit));
          check($sformatf("miss_o@%08h", e.addr), 32'(miss_seen), e.hit ? 0 : 1);
          if (e.hit) check($sformatf("hit_latency@%08h", e.addr), 32'(cyc - e.cyc), 1);
        end
        miss_seen = 0;
      end
    end
  end

  task automatic finish_run();
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("ar_queue_drained", 32'(ar_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_pready"}, 32'(in_pready), 0);
    check({tag, "_perr"}, 32'(in_perr), 0);
    check({tag, "_arvalid"}, 32'(axi_arvalid), 0);
    check({tag, "_rready"}, 32'(axi_rready), 0);
    check({tag, "_hit"}, 32'(hit_o), 0);
    check({tag, "_miss"}, 32'(miss_o), 0);
  endtask

  task automatic fetch(input logic [31:0] addr, input int stall, input int err_beat, input int len,
                       input bit fence_refill, input bit hold, input bit with_fence);
    exp_t e;
    int   idx;
    int   n;
    bit   fenced;
    @(negedge clock);
    if (with_fence) begin
      fence_i_i = 1'b1;
      m_valid = '0;
    end
    idx    = int'(addr[7:4]);
    e.addr = addr;
    e.data = mem_word(addr);
    e.cyc  = cyc;
    e.hit  = m_valid[idx] && (m_tag[idx] == addr[31:8]);
    e.err  = 1'b0;
    if (!e.hit) begin
      e.err = (err_beat >= 0) && (err_beat < len);
      ar_q.push_back({addr[31:4], 4'h0});
      cur_stall = stall; cur_err = err_beat; cur_len = len;
      m_tag[idx]   = addr[31:8];
      m_valid[idx] = !e.err && (len == 4);
    end
    sb.push_back(e);
    in_psel = 1'b1;
    in_paddr = addr;
    fenced = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clock);
      fence_i_i = 1'b0;
      if (fence_refill && !fenced && axi_rready) begin
        fence_i_i = 1'b1;
        fenced = 1;
      end
      if (in_pready) break;
    end
    if (n == 300) begin
      vectors++;
      miscompares++;
      $display("FAIL fetch_timeout: no pready for 0x%08h within 300 cycles, expected one", addr);
      finish_run();
    end
    if (fenced) m_valid = '0;
    in_psel = hold;
    @(negedge clock);
    in_psel = 1'b0;
  endtask

  task automatic fence_pulse();
    @(negedge clock);
    fence_i_i = 1'b1;
    m_valid = '0;
    @(negedge clock);
    fence_i_i = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) ovr[32'h3000_0000 + 4 * i] = 32'h11 * (i + 1);

    repeat (3) @(negedge clock);
    check_outputs_clear("reset");
    reset = 1'b1;

    fetch(32'h3000_0000, 0, -1, 4, 0, 0, 0);   // cold miss -> 0x11
    fetch(32'h3000_0008, 0, -1, 4, 0, 0, 0);   // hit -> 0x33
    fetch(32'h3000_0100, 0, -1, 4, 0, 0, 0);   // same index, evicts
    fetch(32'h3000_0000, 0, -1, 4, 0, 1, 0);   // misses again
    cur_gap = 50;
    fetch(32'h3000_0204, 5, -1, 4, 0, 0, 0);   // backpressure on AR and R
    cur_gap = 0;
    fetch(32'h3000_0310, 0, 1, 4, 0, 0, 0);    // error beat
    fetch(32'h3000_0314, 0, -1, 4, 0, 0, 0);   // line was not kept
    fetch(32'h3000_0318, 0, -1, 4, 0, 1, 0);   // now a hit
    fetch(32'h3000_0000, 0, -1, 4, 0, 0, 1);   // fence together with psel
    fetch(32'h3000_0020, 0, -1, 4, 1, 0, 0);   // fence during refill
    fetch(32'h3000_0020, 0, -1, 4, 0, 0, 0);
    fetch(32'h3000_0000, 0, -1, 4, 0, 0, 0);
    fetch(32'h3000_0430, 0, -1, 2, 0, 0, 0);   // early rlast
    fetch(32'h3000_0434, 0, -1, 4, 0, 0, 0);

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int st, eb, ln;
      bit fr, hd, wf;
      a = 32'h3000_0000 + ($urandom_range(0, 2) * 32'h1000) + ($urandom_range(0, 7) * 16)
          + ($urandom_range(0, 3) * 4);
      st = $urandom_range(0, 3);
      cur_gap = $urandom_range(0, 40);
      eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      ln = 4;
      if ($urandom_range(0, 19) == 0) begin
        ln = $urandom_range(1, 3);
        a[3:0] = 4'h0;
      end
      fr = ($urandom_range(0, 19) == 0);
      hd = ($urandom_range(0, 4) == 0);
      wf = ($urandom_range(0, 19) == 0);
      fetch(a, st, eb, ln, fr, hd, wf);
      if ($urandom_range(0, 29) == 0) fence_pulse();
    end

    // reset in the middle of a refill
    @(negedge clock);
    cur_stall = 0; cur_err = -1; cur_len = 4; cur_gap = 60;
    if (!(m_valid[5] && m_tag[5] == 24'h300_0f0)) ar_q.push_back(32'h3000_f050);
    in_psel = 1'b1;
    in_paddr = 32'h3000_f050;
    n = 0;
    while (!axi_rready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("refill_reached", 32'(axi_rready), 1);
    reset = 1'b0;
    in_psel = 1'b0;
    @(negedge clock);
    check_outputs_clear("mid_refill_reset");
    @(negedge clock);
    reset = 1'b1;
    ar_q.delete();
    m_valid = '0;
    cur_gap = 0;

    fetch(32'h3000_0000, 0, -1, 4, 0, 0, 0);
    fetch(32'h3000_f050, 0, -1, 4, 0, 0, 0);
    fetch(32'h3000_f05c, 0, -1, 4, 0, 0, 0);
    repeat (3) @(negedge clock);
    finish_run();
  end

endmodule
